// File: rtl/bbc_keyboard_matrix.sv
// BBC micro keyboard matrix: column counter, row/column decode, PA7 key sense and CA2 column interrupt.
// Optional macro BBC_KEYBOARD_MATRIX_DIP_SWITCHES_EN maps dip_switches onto row 0 of columns 2-9.
module bbc_keyboard_matrix (
  input  logic        clk,
  input  logic        clk__enable,
  input  logic        reset_n,
  input  logic        keyboard__reset_pressed,
  input  logic [63:0] keyboard__keys_down_cols_0_to_7,
  input  logic [15:0] keyboard__keys_down_cols_8_to_9,
  input  logic        keyboard_enable_n,
  input  logic [3:0]  column_select,
  input  logic [2:0]  row_select,
`ifdef BBC_KEYBOARD_MATRIX_DIP_SWITCHES_EN
  input  logic [7:0]  dip_switches,
`endif
  output logic        key_pressed,
  output logic        key_in_column_pressed,
  output logic [3:0]  column_counter,
  output logic        break_pressed
);

  logic [79:0] keys_p0;
  logic        col_hit_p0;
  logic        sel_hit_p0;
  logic [3:0]  column_counter_p1;
  logic        key_pressed_p1;
  logic        key_in_column_p1;
  logic        break_p1;

  // Columns 10-15 have no keys fitted and always read as released.
  function automatic logic key_at(input logic [79:0] keys, input logic [3:0] c, input logic [2:0] r);
    logic [6:0] idx;
    idx = {c, r};
    if (c < 4'd10) key_at = keys[idx];
    else           key_at = 1'b0;
  endfunction

  // Stage p0: effective key map and decode
  always_comb begin
    keys_p0 = {keyboard__keys_down_cols_8_to_9, keyboard__keys_down_cols_0_to_7};
`ifdef BBC_KEYBOARD_MATRIX_DIP_SWITCHES_EN
    for (int c = 2; c < 10; c++) begin
      keys_p0[c*8] = dip_switches[c-2];
    end
`endif
    col_hit_p0 = 1'b0;
    for (int r = 1; r < 8; r++) begin
      col_hit_p0 = col_hit_p0 | key_at(keys_p0, column_counter_p1, 3'(r));
    end
    sel_hit_p0 = key_at(keys_p0, column_select, row_select);
  end

  // Stage p1: registered outputs, advanced only on enabled cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      column_counter_p1 <= 4'd0;
      key_pressed_p1    <= 1'b0;
      key_in_column_p1  <= 1'b0;
      break_p1          <= 1'b0;
    end else if (clk__enable) begin
      column_counter_p1 <= keyboard_enable_n ? column_counter_p1 + 4'd1 : column_select;
      key_pressed_p1    <= ~keyboard_enable_n & sel_hit_p0;
      key_in_column_p1  <= col_hit_p0;
      break_p1          <= keyboard__reset_pressed;
    end
  end

  assign column_counter        = column_counter_p1;
  assign key_pressed           = key_pressed_p1;
  assign key_in_column_pressed = key_in_column_p1;
  assign break_pressed         = break_p1;

endmodule

// File: tb/tb_bbc_keyboard_matrix.sv
// Directed bench for bbc_keyboard_matrix: reset, manual scan, high columns, CA2, gating, BREAK.
module tb_bbc_keyboard_matrix;
  logic        clk = 1'b0;
  logic        clk__enable;
  logic        reset_n;
  logic        keyboard__reset_pressed;
  logic [63:0] keys_lo;
  logic [15:0] keys_hi;
  logic        keyboard_enable_n;
  logic [3:0]  column_select;
  logic [2:0]  row_select;
`ifdef BBC_KEYBOARD_MATRIX_DIP_SWITCHES_EN
  logic [7:0]  dip_switches;
`endif
  logic        key_pressed;
  logic        key_in_column_pressed;
  logic [3:0]  column_counter;
  logic        break_pressed;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_cnt;

  bbc_keyboard_matrix dut (
    .clk(clk),
    .clk__enable(clk__enable),
    .reset_n(reset_n),
    .keyboard__reset_pressed(keyboard__reset_pressed),
    .keyboard__keys_down_cols_0_to_7(keys_lo),
    .keyboard__keys_down_cols_8_to_9(keys_hi),
    .keyboard_enable_n(keyboard_enable_n),
    .column_select(column_select),
    .row_select(row_select),
`ifdef BBC_KEYBOARD_MATRIX_DIP_SWITCHES_EN
    .dip_switches(dip_switches),
`endif
    .key_pressed(key_pressed),
    .key_in_column_pressed(key_in_column_pressed),
    .column_counter(column_counter),
    .break_pressed(break_pressed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clk__enable = 1'b1;
    keyboard__reset_pressed = 1'b1;
    keys_lo = '1;
    keys_hi = '1;
    keyboard_enable_n = 1'b1;
    column_select = 4'd3;
    row_select = 3'd1;
`ifdef BBC_KEYBOARD_MATRIX_DIP_SWITCHES_EN
    dip_switches = 8'h00;
`endif
    repeat (3) tick();
    total++; if (column_counter !== 4'd0) begin bad++; $display("FAIL reset_counter got=%0d want=0", column_counter); end
    total++; if (key_pressed !== 1'b0) begin bad++; $display("FAIL reset_key_pressed got=%b want=0", key_pressed); end
    total++; if (key_in_column_pressed !== 1'b0) begin bad++; $display("FAIL reset_kicp got=%b want=0", key_in_column_pressed); end
    total++; if (break_pressed !== 1'b0) begin bad++; $display("FAIL reset_break got=%b want=0", break_pressed); end
    keys_lo = '0;
    keys_hi = '0;
    keyboard__reset_pressed = 1'b0;
    reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      total++;
      if (column_counter !== 4'(i)) begin
        bad++; $display("FAIL autoscan_seq step=%0d got=%0d want=%0d", i, column_counter, 4'(i));
      end
    end
  endtask

  task automatic test_manual();
    keyboard_enable_n = 1'b0;
    keys_lo = 64'd1 << (8*3+5);
    column_select = 4'd3;
    row_select = 3'd5;
    tick();
    total++; if (key_pressed !== 1'b1) begin bad++; $display("FAIL manual_hit got=%b want=1", key_pressed); end
    total++; if (column_counter !== 4'd3) begin bad++; $display("FAIL manual_counter got=%0d want=3", column_counter); end
    row_select = 3'd4;
    tick();
    total++; if (key_pressed !== 1'b0) begin bad++; $display("FAIL manual_miss got=%b want=0", key_pressed); end
    // Autoscan forces PA7 low even with the selected key down
    row_select = 3'd5;
    keyboard_enable_n = 1'b1;
    tick();
    total++; if (key_pressed !== 1'b0) begin bad++; $display("FAIL autoscan_pa7 got=%b want=0", key_pressed); end
  endtask

  task automatic test_high_cols();
    keyboard_enable_n = 1'b0;
    keys_lo = '0;
    keys_hi = 16'd1 << (8*1+2);
    column_select = 4'd9;
    row_select = 3'd2;
    tick();
    total++; if (key_pressed !== 1'b1) begin bad++; $display("FAIL col9_row2 got=%b want=1", key_pressed); end
    column_select = 4'd8;
    tick();
    total++; if (key_pressed !== 1'b0) begin bad++; $display("FAIL col8_row2 got=%b want=0", key_pressed); end
    keys_lo = '1;
    keys_hi = '1;
    column_select = 4'd12;
    row_select = 3'd3;
    tick();
    tick();
    total++; if (key_pressed !== 1'b0) begin bad++; $display("FAIL col12 got=%b want=0", key_pressed); end
    total++; if (key_in_column_pressed !== 1'b0) begin bad++; $display("FAIL col12_kicp got=%b want=0", key_in_column_pressed); end
  endtask

  // Parks the counter at column 0 with no keys down, then resumes autoscan.
  task automatic align_to_zero();
    keys_lo = '0;
    keys_hi = '0;
    keyboard_enable_n = 1'b0;
    column_select = 4'd0;
    tick();
    tick();
    keyboard_enable_n = 1'b1;
    exp_cnt = 4'd0;
  endtask

  task automatic scan_cycles(input int n, input logic row7, input int want_pulses);
    int pulses;
    logic exp_k;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      exp_k = row7 && (exp_cnt == 4'd4);
      exp_cnt = exp_cnt + 4'd1;
      tick();
      if (key_in_column_pressed === 1'b1) pulses++;
      total++;
      if (key_in_column_pressed !== exp_k || column_counter !== exp_cnt) begin
        bad++; $display("FAIL ca2_scan i=%0d kicp=%b want=%b cnt=%0d want=%0d", i, key_in_column_pressed, exp_k, column_counter, exp_cnt);
      end
    end
    total++;
    if (pulses != want_pulses) begin bad++; $display("FAIL ca2_pulse_count got=%0d want=%0d", pulses, want_pulses); end
  endtask

  task automatic test_row0_exclusion();
    align_to_zero();
    keys_lo = 64'd1 << (8*4+0);
    scan_cycles(32, 1'b0, 0);
    keys_lo = (64'd1 << (8*4+0)) | (64'd1 << (8*4+7));
    scan_cycles(32, 1'b1, 2);
  endtask

  task automatic test_enable_gating();
    clk__enable = 1'b0;
    keyboard__reset_pressed = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (column_counter !== exp_cnt || break_pressed !== 1'b0) begin
        bad++; $display("FAIL gated_hold i=%0d cnt=%0d want=%0d brk=%b want=0", i, column_counter, exp_cnt, break_pressed);
      end
    end
    clk__enable = 1'b1;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    total++; if (break_pressed !== 1'b1) begin bad++; $display("FAIL break_rise got=%b want=1", break_pressed); end
    total++; if (column_counter !== exp_cnt) begin bad++; $display("FAIL gated_resume got=%0d want=%0d", column_counter, exp_cnt); end
    keyboard__reset_pressed = 1'b0;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    total++; if (break_pressed !== 1'b0) begin bad++; $display("FAIL break_fall got=%b want=0", break_pressed); end
  endtask

  task automatic test_switch_manual();
    logic exp_k;
    // Counter sits away from 4 so CA2 only rises after the counter reaches the selected column
    align_to_zero();
    keys_lo = 64'd1 << (8*4+7);
    keyboard_enable_n = 1'b0;
    column_select = 4'd4;
    tick();
    total++; if (column_counter !== 4'd4) begin bad++; $display("FAIL switch_cnt got=%0d want=4", column_counter); end
    total++; if (key_in_column_pressed !== 1'b0) begin bad++; $display("FAIL switch_kicp1 got=%b want=0", key_in_column_pressed); end
    tick();
    exp_k = 1'b1;
    total++; if (key_in_column_pressed !== exp_k) begin bad++; $display("FAIL switch_kicp2 got=%b want=1", key_in_column_pressed); end
  endtask

  task automatic test_async_reset();
    align_to_zero();
    repeat (6) tick();
    total++; if (column_counter !== 4'd6) begin bad++; $display("FAIL pre_reset_cnt got=%0d want=6", column_counter); end
    reset_n = 1'b0;
    #1;
    total++; if (column_counter !== 4'd0) begin bad++; $display("FAIL async_reset got=%0d want=0", column_counter); end
    #1;
    reset_n = 1'b1;
    tick();
    total++; if (column_counter !== 4'd1) begin bad++; $display("FAIL restart got=%0d want=1", column_counter); end
  endtask

`ifdef BBC_KEYBOARD_MATRIX_DIP_SWITCHES_EN
  task automatic test_dip();
    keys_lo = '0;
    keys_hi = '0;
    dip_switches = 8'h01;
    keyboard_enable_n = 1'b0;
    column_select = 4'd2;
    row_select = 3'd0;
    tick();
    total++; if (key_pressed !== 1'b1) begin bad++; $display("FAIL dip_col2 got=%b want=1", key_pressed); end
    column_select = 4'd3;
    tick();
    total++; if (key_pressed !== 1'b0) begin bad++; $display("FAIL dip_col3 got=%b want=0", key_pressed); end
  endtask
`endif

  initial begin
    test_reset();
    test_manual();
    test_high_cols();
    test_row0_exclusion();
    test_enable_gating();
    test_switch_manual();
    test_async_reset();
`ifdef BBC_KEYBOARD_MATRIX_DIP_SWITCHES_EN
    test_dip();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
